uart_loader: RTL

UART_LOADER -- requirements
Module: uart_loader

---
 rtl/uart_loader_pkg.sv | 17 +
 rtl/uart_rx.sv | 104 ++++++++++
 rtl/uart_loader.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART boot loader: receiver/loader
// state encodings, word size and half-bit timing.
package uart_loader_pkg;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {LD_LEN, LD_LOAD, LD_CHK, LD_DONE} ld_state_e;

  localparam int WORD_BYTES       = 4;
  localparam int CLKS_PER_BIT_DEF = 868;
  localparam int HALF_BIT_DEF     = CLKS_PER_BIT_DEF / 2;

  // Delay from start-bit edge to the middle of the start bit.
  function automatic int half_bit(input int clks_per_bit);
    return clks_per_bit / 2;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, one-cycle
// byte_valid on a good stop bit, frame_err pulse on a bad one.
module uart_rx
  import uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(half_bit(CLKS_PER_BIT) - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  logic             sync1_q, sync2_q, prev_q;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (prev_q && !sync2_q) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = '0;
          // Line back high by mid-start-bit means it was only a glitch.
          state_d = sync2_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shreg_d = {sync2_q, shreg_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          valid_d = sync2_q;
          ferr_d  = !sync2_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_valid = valid_q;
  assign byte_data  = shreg_q;
  assign frame_err  = ferr_q;

endmodule

// File: rtl/uart_loader.sv
// UART boot loader: 32-bit LE length header, then LE words written to
// instruction memory port A; releases the core when done.
// Define UART_LOADER_CHECKSUM_EN to require a trailing XOR checksum word.
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int ADDR_W       = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic [3:0]        we,
  output logic [ADDR_W-1:0] addr,
  output logic [31:0]       din,
  output logic              core_rst_n,
  output logic              done,
  output logic              err
);

  localparam logic [32:0] DEPTH = 33'd1 << ADDR_W;
`ifdef UART_LOADER_CHECKSUM_EN
  localparam ld_state_e AFTER_LOAD = LD_CHK;
`else
  localparam ld_state_e AFTER_LOAD = LD_DONE;
`endif

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       frame_err;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (frame_err)
  );

  ld_state_e         state_q, state_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [31:0]       shift_q, shift_d;
  logic [31:0]       wcount_q, wcount_d;
  logic [31:0]       nwr_q, nwr_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       din_q, din_d;
  logic [3:0]        we_q, we_d;
  logic              err_q, err_d;
`ifdef UART_LOADER_CHECKSUM_EN
  logic [31:0]       csum_q, csum_d;
  logic              bad_q, bad_d;
`endif

  logic [31:0] word;
  logic        last_byte;
  assign word      = {byte_data, shift_q[31:8]};
  assign last_byte = byte_valid && (bcnt_q == 2'(WORD_BYTES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= LD_LEN;
      bcnt_q   <= '0;
      shift_q  <= '0;
      wcount_q <= '0;
      nwr_q    <= '0;
      idx_q    <= '0;
      addr_q   <= '0;
      din_q    <= '0;
      we_q     <= '0;
      err_q    <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
      csum_q   <= '0;
      bad_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      bcnt_q   <= bcnt_d;
      shift_q  <= shift_d;
      wcount_q <= wcount_d;
      nwr_q    <= nwr_d;
      idx_q    <= idx_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      we_q     <= we_d;
      err_q    <= err_d;
`ifdef UART_LOADER_CHECKSUM_EN
      csum_q   <= csum_d;
      bad_q    <= bad_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    bcnt_d   = bcnt_q;
    shift_d  = shift_q;
    wcount_d = wcount_q;
    nwr_d    = nwr_q;
    idx_d    = idx_q;
    addr_d   = addr_q;
    din_d    = din_q;
    we_d     = '0;
    err_d    = err_q;
`ifdef UART_LOADER_CHECKSUM_EN
    csum_d   = csum_q;
    bad_d    = bad_q;
`endif
    if (state_q != LD_DONE) begin
      if (frame_err) err_d = 1'b1;
      if (byte_valid) begin
        shift_d = word;
        bcnt_d  = bcnt_q + 1'b1;
      end
    end
    case (state_q)
      LD_LEN: begin
        if (last_byte) begin
          wcount_d = word;
          if ({1'b0, word} > DEPTH) err_d = 1'b1;
          state_d = (word == 32'h0) ? AFTER_LOAD : LD_LOAD;
        end
      end
      LD_LOAD: begin
        if (last_byte) begin
          we_d   = 4'hF;
          addr_d = idx_q;
          din_d  = word;
          idx_d  = idx_q + 1'b1;
          nwr_d  = nwr_q + 1'b1;
`ifdef UART_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ word;
`endif
          if (nwr_q + 1'b1 == wcount_q) state_d = AFTER_LOAD;
        end
      end
`ifdef UART_LOADER_CHECKSUM_EN
      LD_CHK: begin
        if (last_byte) begin
          state_d = LD_DONE;
          if (word != csum_q) begin
            err_d = 1'b1;
            bad_d = 1'b1;
          end
        end
      end
`endif
      default: ;
    endcase
  end

  assign we   = we_q;
  assign addr = addr_q;
  assign din  = din_q;
  assign done = (state_q == LD_DONE);
  assign err  = err_q;
`ifdef UART_LOADER_CHECKSUM_EN
  assign core_rst_n = (state_q == LD_DONE) && !bad_q;
`else
  assign core_rst_n = (state_q == LD_DONE);
`endif

endmodule
